// File: rtl/pwm_fader_pkg.sv
// pwm_fader_pkg: shared constants and the fade-step rule for pwm_fader.
//
// Contents:
//   DIR_UP / DIR_DOWN       - bounce direction encoding.
//   MODE_WRAP / MODE_BOUNCE - fade mode encoding, matching the 'bounce' pin.
//   next_target()           - one fade step for one channel.
//
// next_target() works on FN_W-bit operands so that a single package
// function serves any channel width. The caller passes its real width.
// The result is packed as {dir', t'} in the low width+1 bits, with dir'
// at bit position 'width'. Bits above that are always zero.
package pwm_fader_pkg;

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Widest channel the helper supports, plus one bit for dir.
  localparam int unsigned FN_W = 32;

  function automatic logic [FN_W:0] next_target(
    input logic [FN_W-1:0] t,
    input logic [FN_W-1:0] s,
    input logic            dir,
    input logic            mode,
    input int unsigned     width
  );
    logic [FN_W:0]   max_v;
    logic [FN_W:0]   sum;
    logic [FN_W-1:0] nt;
    logic            nd;
    max_v = (33'd1 << width) - 33'd1;
    // One extra bit so the saturation test below cannot overflow.
    sum   = {1'b0, t} + {1'b0, s};
    nt    = t;
    nd    = dir;
    if (s != '0) begin
      if (mode == MODE_WRAP) begin
        nt = sum[FN_W-1:0] & max_v[FN_W-1:0];
      end else if (dir == DIR_UP) begin
        if (sum >= max_v) begin
          nt = max_v[FN_W-1:0];
          nd = DIR_DOWN;
        end else begin
          nt = sum[FN_W-1:0];
        end
      end else begin
        if (t <= s) begin
          nt = '0;
          nd = DIR_UP;
        end else begin
          nt = t - s;
        end
      end
    end
    return ((FN_W+1)'(nd) << width) | {1'b0, nt};
  endfunction

endpackage

// File: rtl/pwm_fader_chan.sv
// pwm_fader_chan: one fader channel.
//
// Holds the fade target and bounce direction. It also holds the duty that is
// currently applied and the registered PWM compare.
//
// Ports:
//   sys_clk, sys_rst_n - clock and asynchronous active-low reset.
//   tick               - one-cycle fade tick. Step and mode are sampled here.
//   apply              - last cycle of the PWM period. Target moves into duty.
//   bounce             - fade mode: 0 = wrap, 1 = bounce.
//   step               - increment applied on each tick.
//   cnt                - shared PWM period counter.
//   duty               - currently applied duty.
//   pwm_out            - PWM pin after polarity, registered.
module pwm_fader_chan
  import pwm_fader_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_DUTY  = '0,
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick,
  input  logic             apply,
  input  logic             bounce,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] duty,
  output logic             pwm_out
);

  logic [WIDTH-1:0] target;
  logic             dir;
  logic [FN_W:0]    nxt_full;
  logic [FN_W-WIDTH-1:0] nxt_unused;

  assign nxt_full   = next_target(FN_W'(target), FN_W'(step), dir,
                                  bounce ? MODE_BOUNCE : MODE_WRAP, WIDTH);
  // Above {dir', t'} the helper returns zeros.
  assign nxt_unused = nxt_full[FN_W:WIDTH+1];

  // NOTE: every state register here uses non-blocking assignment. This way
  // 'apply' reads the pre-tick target when tick and apply coincide, and
  // the compare reads the duty as it was before this edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      target  <= INIT_DUTY;
      dir     <= DIR_UP;
      duty    <= INIT_DUTY;
      pwm_out <= ACTIVE_LOW;
    end else begin
      if (tick) begin
        {dir, target} <= nxt_full[WIDTH:0];
      end
      if (apply) begin
        duty <= target;
      end
      pwm_out <= (cnt < duty) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM LED fader.
//
// All channels share one PWM period counter of MAX = 2^WIDTH-1 clocks.
// The duty of each channel steps once per fade tick, by its own increment.
// The fade mode is wrap (sawtooth) or bounce (triangle). A new duty is only
// taken up on the last cycle of a period, so the pins never glitch.
//
// Ports:
//   sys_clk, sys_rst_n - clock and asynchronous active-low reset.
//   enable             - 1 = fade ticks advance. 0 = duty frozen while PWM runs.
//   bounce             - 0 = wrap mode, 1 = bounce mode. Applies to all channels.
//   step               - per-channel increment; channel k = step[k*WIDTH +: WIDTH].
//   pwm_out            - PWM pins after polarity.
//   duty               - applied duty per channel. Packed the same way as step.
//   period_start       - one-cycle pulse on the first cycle of each PWM period.
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 1350000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int INIT_DUTY  = 100
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      enable,
  input  logic                      bounce,
  input  logic [CHANNELS*WIDTH-1:0] step,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*WIDTH-1:0] duty,
  output logic                      period_start
);

  localparam int              PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  // cnt runs 0..MAX-1, so its last value is MAX-1 = all ones except the LSB.
  localparam logic [WIDTH-1:0]   CNT_LAST   = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   cnt;
  logic               tick;
  logic               apply;

  assign tick  = enable && (presc == PRESC_LAST);
  assign apply = (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc        <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      // presc only advances while enabled. When enable returns, fading
      // resumes from the same point in the interval.
      if (enable) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
      cnt          <= apply ? '0 : cnt + 1'b1;
      period_start <= (cnt == '0);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    pwm_fader_chan #(
      .WIDTH      (WIDTH),
      .INIT_DUTY  (WIDTH'(INIT_DUTY)),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick      (tick),
      .apply     (apply),
      .bounce    (bounce),
      .step      (step[k*WIDTH +: WIDTH]),
      .cnt       (cnt),
      .duty      (duty[k*WIDTH +: WIDTH]),
      .pwm_out   (pwm_out[k])
    );
  end

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: scoreboard bench for pwm_fader (WIDTH=4, TICK_DIV=4, 3 channels,
// active-low, INIT_DUTY=5).
//
// The stimulus process drives random inputs. Every cycle it also runs a
// per-period reference model, which is built from the fade rules as plain
// integer arithmetic. Whenever the model reaches a period boundary, it pushes
// the duty vector expected for the next period onto a queue.
//
// The monitor waits for each period_start and pops the expected duty. It
// compares duty against that value. It then checks the full 15-cycle pwm_out
// waveform and the period_start pattern for that period.
module tb_pwm_fader;

  localparam int CH   = 3;
  localparam int W    = 4;
  localparam int TD   = 4;
  localparam int MAXV = 15;
  localparam int INIT = 5;
  localparam int NPER = 85;
  localparam int NCYC = NPER * MAXV + 20;

  typedef logic [CH*W-1:0] duty_vec_t;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            enable    = 1'b0;
  logic            bounce    = 1'b0;
  duty_vec_t       step      = '0;
  logic [CH-1:0]   pwm_out;
  duty_vec_t       duty;
  logic            period_start;

  int vectors     = 0;
  int miscompares = 0;

  duty_vec_t exp_q[$];
  int        m_tgt[CH];
  bit        m_down[CH];
  int        m_en_cnt;

  always #5 sys_clk = ~sys_clk;

  pwm_fader #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .TICK_DIV   (TD),
    .ACTIVE_LOW (1'b1),
    .INIT_DUTY  (INIT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .bounce       (bounce),
    .step         (step),
    .pwm_out      (pwm_out),
    .duty         (duty),
    .period_start (period_start)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  function automatic duty_vec_t rand_step();
    duty_vec_t v;
    v = '0;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(0, 5))
        0:       v[k*W +: W] = '0;
        1:       v[k*W +: W] = W'(MAXV);
        default: v[k*W +: W] = W'($urandom_range(1, MAXV));
      endcase
    end
    return v;
  endfunction

  // Phases: wrap mode with the step changing every cycle; bounce mode with
  // steady steps; 80 cycles disabled while the step keeps changing; then a
  // mixed phase that toggles the mode.
  task automatic drive_inputs(input int j);
    if (j < 300) begin
      enable = 1'b1;
      bounce = 1'b0;
      step   = rand_step();
    end else if (j < 700) begin
      enable = 1'b1;
      bounce = 1'b1;
      if (j == 300 || $urandom_range(0, 39) == 0) step = rand_step();
    end else if (j < 780) begin
      enable = 1'b0;
      step   = rand_step();
    end else begin
      enable = 1'b1;
      if (j % 50 == 0) bounce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) step = rand_step();
    end
  endtask

  // Reference model for the cycle that ends at the next rising edge. The
  // inputs are the values just driven.
  task automatic model_cycle(input int j);
    bit        tick;
    int        s;
    duty_vec_t v;
    tick = 1'b0;
    if (enable) begin
      tick = ((m_en_cnt % TD) == TD - 1);
      m_en_cnt++;
    end
    if (j % MAXV == MAXV - 1) begin
      for (int k = 0; k < CH; k++) v[k*W +: W] = W'(m_tgt[k]);
      exp_q.push_back(v);
    end
    if (tick) begin
      for (int k = 0; k < CH; k++) begin
        s = int'(step[k*W +: W]);
        if (s != 0) begin
          if (!bounce) begin
            m_tgt[k] = (m_tgt[k] + s) % (MAXV + 1);
          end else if (!m_down[k]) begin
            if (m_tgt[k] + s >= MAXV) begin
              m_tgt[k]  = MAXV;
              m_down[k] = 1'b1;
            end else begin
              m_tgt[k] = m_tgt[k] + s;
            end
          end else begin
            if (m_tgt[k] <= s) begin
              m_tgt[k]  = 0;
              m_down[k] = 1'b0;
            end else begin
              m_tgt[k] = m_tgt[k] - s;
            end
          end
        end
      end
    end
  endtask

  task automatic monitor(input int nper);
    duty_vec_t       ev;
    logic [MAXV-1:0] got[CH];
    logic [MAXV-1:0] exp_pat;
    logic [MAXV-1:0] ps_bits;
    int              waited;
    int              d;
    for (int p = 0; p < nper; p++) begin
      waited = 0;
      while (!period_start && waited < 2 * MAXV) begin
        @(negedge sys_clk);
        waited++;
      end
      if (!period_start) begin
        fail_now($sformatf("period_start_timeout p%0d", p));
        return;
      end
      if (exp_q.size() == 0) begin
        fail_now($sformatf("scoreboard_empty p%0d", p));
        return;
      end
      ev = exp_q.pop_front();
      for (int k = 0; k < CH; k++)
        check($sformatf("duty_ch%0d_p%0d", k, p), 32'(duty[k*W +: W]),
              32'(ev[k*W +: W]));
      for (int i = 0; i < MAXV; i++) begin
        for (int k = 0; k < CH; k++) got[k][i] = pwm_out[k];
        ps_bits[i] = period_start;
        if (i < MAXV - 1) @(negedge sys_clk);
      end
      for (int k = 0; k < CH; k++) begin
        d = int'(ev[k*W +: W]);
        for (int i = 0; i < MAXV; i++) exp_pat[i] = (i < d) ? 1'b0 : 1'b1;
        check($sformatf("pwm_wave_ch%0d_p%0d", k, p), 32'(got[k]), 32'(exp_pat));
      end
      check($sformatf("period_start_wave_p%0d", p), 32'(ps_bits), 32'd1);
      @(negedge sys_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("reset_pwm_out", 32'(pwm_out), 32'b111);
    check("reset_duty", 32'(duty), 32'({CH{4'd5}}));
    check("reset_period_start", 32'(period_start), 32'd0);

    for (int k = 0; k < CH; k++) begin
      m_tgt[k]  = INIT;
      m_down[k] = 1'b0;
    end
    m_en_cnt = 0;
    exp_q.delete();
    exp_q.push_back({CH{W'(INIT)}});
    sys_rst_n = 1'b1;

    fork
      begin
        for (int j = 0; j < NCYC; j++) begin
          drive_inputs(j);
          model_cycle(j);
          @(negedge sys_clk);
        end
      end
      monitor(NPER);
    join

    // The next reset lands mid-period while every pin is active. The outputs
    // must return to their reset values without waiting for a clock edge.
    enable    = 1'b0;
    step      = '0;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("pre_reset_pwm_active", 32'(pwm_out), 32'b000);
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_pwm_out", 32'(pwm_out), 32'b111);
    check("async_reset_duty", 32'(duty), 32'({CH{4'd5}}));
    check("async_reset_period_start", 32'(period_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
